// File: rtl/vid_pattern_gen.sv
// Video timing source: de/hs/vs with programmable porches and polarity, plus
// a frame-latched test pattern (colour bars, moving ramp, checkerboard, solid).
module vid_pattern_gen #(
  parameter int unsigned H_RES  = 640,
  parameter int unsigned H_FP   = 8,
  parameter int unsigned H_SYNC = 2,
  parameter int unsigned H_BP   = 8,
  parameter int unsigned V_RES  = 480,
  parameter int unsigned V_FP   = 8,
  parameter int unsigned V_SYNC = 4,
  parameter int unsigned V_BP   = 8,
  parameter bit          HS_POL = 1'b0,
  parameter bit          VS_POL = 1'b0,
  parameter int unsigned CW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [1:0]      mode,
  input  logic [3*CW-1:0] solid_rgb,
  output logic            de,
  output logic            hs,
  output logic            vs,
  output logic [CW-1:0]   r,
  output logic [CW-1:0]   g,
  output logic [CW-1:0]   b,
  output logic            sof,
  output logic            eol,
  output logic [15:0]     frame_cnt
);

  localparam int unsigned H_TOT = H_RES + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_RES + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned BARW  = H_RES / 8;
  localparam int unsigned BW    = (BARW > 1) ? $clog2(BARW) : 1;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [1:0]    mode_q;
  logic [BW-1:0] bar_px;
  logic [2:0]    bar_idx;

  logic [31:0]   hx, vx;
  logic          h_last, v_last, frame_start, active, in_hs, in_vs, line_end;
  logic [1:0]    mode_c;
  logic [2:0]    bar_bits;
  logic [CW-1:0] pix_r, pix_g, pix_b, ramp;

  assign hx          = 32'(hcnt);
  assign vx          = 32'(vcnt);
  assign h_last      = (hx == H_TOT - 1);
  assign v_last      = (vx == V_TOT - 1);
  assign frame_start = (hx == 0) && (vx == 0);
  assign active      = (hx < H_RES) && (vx < V_RES);
  assign line_end    = (hx == H_RES - 1) && (vx < V_RES);
  assign in_hs       = (hx >= H_RES + H_FP) && (hx < H_RES + H_FP + H_SYNC);
  assign in_vs       = (vx >= V_RES + V_FP) && (vx < V_RES + V_FP + V_SYNC);
  assign ramp        = CW'(hcnt) + CW'(frame_cnt);

  // Pixel for the current counter state; the new mode takes effect on pixel (0,0)
  always_comb begin
    mode_c = frame_start ? mode : mode_q;
    pix_r  = '0;
    pix_g  = '0;
    pix_b  = '0;
    case (bar_idx)
      3'd0:    bar_bits = 3'b111;
      3'd1:    bar_bits = 3'b110;
      3'd2:    bar_bits = 3'b011;
      3'd3:    bar_bits = 3'b010;
      3'd4:    bar_bits = 3'b101;
      3'd5:    bar_bits = 3'b100;
      3'd6:    bar_bits = 3'b001;
      default: bar_bits = 3'b000;
    endcase
    case (mode_c)
      2'd0: begin
        pix_r = {CW{bar_bits[2]}};
        pix_g = {CW{bar_bits[1]}};
        pix_b = {CW{bar_bits[0]}};
      end
      2'd1: begin
        pix_r = ramp;
        pix_g = ramp;
        pix_b = ramp;
      end
      2'd2: begin
        pix_r = {CW{hx[5] ^ vx[5]}};
        pix_g = {CW{hx[5] ^ vx[5]}};
        pix_b = {CW{hx[5] ^ vx[5]}};
      end
      default: begin
        pix_r = solid_rgb[3*CW-1:2*CW];
        pix_g = solid_rgb[2*CW-1:CW];
        pix_b = solid_rgb[CW-1:0];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt      <= '0;
      vcnt      <= '0;
      mode_q    <= '0;
      bar_px    <= '0;
      bar_idx   <= '0;
      frame_cnt <= '0;
      de        <= 1'b0;
      hs        <= ~HS_POL;
      vs        <= ~VS_POL;
      r         <= '0;
      g         <= '0;
      b         <= '0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else if (ce) begin
      hcnt <= h_last ? '0 : hcnt + HW'(1);
      if (h_last) vcnt <= v_last ? '0 : vcnt + VW'(1);
      if (h_last && v_last) frame_cnt <= frame_cnt + 16'd1;
      if (frame_start) mode_q <= mode;
      // Bar index follows hcnt by counting pixels within a bar, saturating at 7
      if (h_last) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == BW'(BARW - 1)) begin
        bar_px <= '0;
        if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + BW'(1);
      end
      de  <= active;
      hs  <= in_hs ? HS_POL : ~HS_POL;
      vs  <= in_vs ? VS_POL : ~VS_POL;
      r   <= active ? pix_r : '0;
      g   <= active ? pix_g : '0;
      b   <= active ? pix_b : '0;
      sof <= frame_start;
      eol <= line_end;
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Bench for vid_pattern_gen: three parameterisations driven by shared stimulus,
// each checked every cycle against a pixel-index reference model.
module tb_vid_pattern_gen;

  typedef struct {
    int unsigned hres, hfp, hsync, hbp, vres, vfp, vsync, vbp, cw;
    bit hpol, vpol;
  } cfg_t;

  typedef struct {
    bit de, hs, vs, sof, eol;
    longint unsigned r, g, b, fc;
  } obs_t;

  typedef struct {
    longint p;
    bit de, hs, sof, eol;
    logic [23:0] rgb;
  } vec_t;

  logic clk, rst, ce;
  logic [1:0]  mode;
  logic [23:0] solid;

  logic de_a, hs_a, vs_a, sof_a, eol_a;
  logic [7:0] r_a, g_a, b_a;
  logic [15:0] fc_a;
  logic de_b, hs_b, vs_b, sof_b, eol_b;
  logic [7:0] r_b, g_b, b_b;
  logic [15:0] fc_b;
  logic de_c, hs_c, vs_c, sof_c, eol_c;
  logic [5:0] r_c, g_c, b_c;
  logic [15:0] fc_c;

  int checks = 0, failures = 0;
  longint cyc = 0;
  cfg_t cfg[3];
  longint p[3];
  bit [1:0] fm[3];
  bit [23:0] sol[3];
  int de_cnt_b, sof_cnt_b;
  longint sof_last_b, sof_gap_b;

  vid_pattern_gen dut_a (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .solid_rgb(solid),
    .de(de_a), .hs(hs_a), .vs(vs_a), .r(r_a), .g(g_a), .b(b_a),
    .sof(sof_a), .eol(eol_a), .frame_cnt(fc_a));

  vid_pattern_gen #(.H_RES(40), .H_FP(3), .H_SYNC(2), .H_BP(3),
                    .V_RES(70), .V_FP(2), .V_SYNC(2), .V_BP(2)) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .solid_rgb(solid),
    .de(de_b), .hs(hs_b), .vs(vs_b), .r(r_b), .g(g_b), .b(b_b),
    .sof(sof_b), .eol(eol_b), .frame_cnt(fc_b));

  vid_pattern_gen #(.H_RES(100), .H_FP(4), .H_SYNC(2), .H_BP(4),
                    .V_RES(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
                    .HS_POL(1'b1), .VS_POL(1'b1), .CW(6)) dut_c (
    .clk(clk), .rst(rst), .ce(ce), .mode(mode), .solid_rgb(solid[17:0]),
    .de(de_c), .hs(hs_c), .vs(vs_c), .r(r_c), .g(g_c), .b(b_c),
    .sof(sof_c), .eol(eol_c), .frame_cnt(fc_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint tot(input cfg_t c);
    return longint'(c.hres + c.hfp + c.hsync + c.hbp) * longint'(c.vres + c.vfp + c.vsync + c.vbp);
  endfunction

  // Expected outputs after the edge that presented global pixel index p (p<0: reset)
  function automatic obs_t expect_px(input cfg_t c, input longint pp, input bit [1:0] fmode,
                                     input bit [23:0] sv);
    obs_t o;
    longint ht, vt, h, v, f, mx, idx;
    bit [2:0] bars[8];
    bars = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};
    ht = c.hres + c.hfp + c.hsync + c.hbp;
    vt = c.vres + c.vfp + c.vsync + c.vbp;
    mx = (longint'(1) << c.cw) - 1;
    o = '{de: 0, hs: !c.hpol, vs: !c.vpol, sof: 0, eol: 0, r: 0, g: 0, b: 0, fc: 0};
    if (pp < 0) return o;
    h = pp % ht;
    v = (pp / ht) % vt;
    f = pp / (ht * vt);
    o.de  = (h < c.hres) && (v < c.vres);
    o.hs  = (h >= c.hres + c.hfp && h < c.hres + c.hfp + c.hsync) ? c.hpol : !c.hpol;
    o.vs  = (v >= c.vres + c.vfp && v < c.vres + c.vfp + c.vsync) ? c.vpol : !c.vpol;
    o.sof = (h == 0) && (v == 0);
    o.eol = (h == c.hres - 1) && (v < c.vres);
    o.fc  = longint'((pp + 1) / (ht * vt)) % 65536;
    if (o.de) begin
      case (fmode)
        2'd0: begin
          idx = h / (c.hres / 8);
          if (idx > 7) idx = 7;
          o.r = bars[idx][2] ? mx : 0;
          o.g = bars[idx][1] ? mx : 0;
          o.b = bars[idx][0] ? mx : 0;
        end
        2'd1: begin
          o.r = (h + f) & mx;
          o.g = o.r;
          o.b = o.r;
        end
        2'd2: begin
          o.r = (((h >> 5) ^ (v >> 5)) & 1) != 0 ? mx : 0;
          o.g = o.r;
          o.b = o.r;
        end
        default: begin
          o.r = (longint'(sv) >> (2 * c.cw)) & mx;
          o.g = (longint'(sv) >> c.cw) & mx;
          o.b = longint'(sv) & mx;
        end
      endcase
    end
    return o;
  endfunction

  function automatic obs_t get_act(input int d);
    obs_t o;
    case (d)
      0: o = '{de: de_a, hs: hs_a, vs: vs_a, sof: sof_a, eol: eol_a, r: r_a, g: g_a, b: b_a, fc: fc_a};
      1: o = '{de: de_b, hs: hs_b, vs: vs_b, sof: sof_b, eol: eol_b, r: r_b, g: g_b, b: b_b, fc: fc_b};
      default: o = '{de: de_c, hs: hs_c, vs: vs_c, sof: sof_c, eol: eol_c, r: r_c, g: g_c, b: b_c, fc: fc_c};
    endcase
    return o;
  endfunction

  task automatic chk(input int d, input string f, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s cycle=%0d actual=%0h expected=%0h", d, f, cyc, act, exp);
    end
  endtask

  task automatic compare_all(input int d);
    obs_t a, e;
    a = get_act(d);
    e = expect_px(cfg[d], p[d], fm[d], sol[d]);
    chk(d, "de", a.de, e.de);
    chk(d, "hs", a.hs, e.hs);
    chk(d, "vs", a.vs, e.vs);
    chk(d, "sof", a.sof, e.sof);
    chk(d, "eol", a.eol, e.eol);
    chk(d, "r", a.r, e.r);
    chk(d, "g", a.g, e.g);
    chk(d, "b", a.b, e.b);
    chk(d, "frame_cnt", a.fc, e.fc);
  endtask

  // One clock: advance the models with the inputs seen at the edge, then check
  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        p[i] = -1;
        fm[i] = 2'd0;
        sol[i] = '0;
      end else if (ce) begin
        p[i]++;
        if (p[i] % tot(cfg[i]) == 0) fm[i] = mode;
        sol[i] = solid;
      end
    end
    #1;
    cyc++;
    for (int i = 0; i < 3; i++) compare_all(i);
    if (de_b) de_cnt_b++;
    if (sof_b) begin
      if (sof_cnt_b > 0) sof_gap_b = cyc - sof_last_b;
      sof_last_b = cyc;
      sof_cnt_b++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    de_cnt_b = 0;
    sof_cnt_b = 0;
    sof_last_b = 0;
    sof_gap_b = 0;
  endtask

  task automatic run_until(input int d, input longint target, input int budget);
    int n;
    n = 0;
    while (p[d] != target && n < budget) begin
      step();
      n++;
    end
    if (p[d] != target) chk(d, "reach_target", longint'(p[d]), longint'(target));
  endtask

  initial begin
    vec_t tbl[11];
    int eol_cnt;
    tbl[0]  = '{p: 0,   de: 1, hs: 1, sof: 1, eol: 0, rgb: 24'hFFFFFF};
    tbl[1]  = '{p: 79,  de: 1, hs: 1, sof: 0, eol: 0, rgb: 24'hFFFFFF};
    tbl[2]  = '{p: 80,  de: 1, hs: 1, sof: 0, eol: 0, rgb: 24'hFFFF00};
    tbl[3]  = '{p: 639, de: 1, hs: 1, sof: 0, eol: 1, rgb: 24'h000000};
    tbl[4]  = '{p: 640, de: 0, hs: 1, sof: 0, eol: 0, rgb: 24'h000000};
    tbl[5]  = '{p: 647, de: 0, hs: 1, sof: 0, eol: 0, rgb: 24'h000000};
    tbl[6]  = '{p: 648, de: 0, hs: 0, sof: 0, eol: 0, rgb: 24'h000000};
    tbl[7]  = '{p: 649, de: 0, hs: 0, sof: 0, eol: 0, rgb: 24'h000000};
    tbl[8]  = '{p: 650, de: 0, hs: 1, sof: 0, eol: 0, rgb: 24'h000000};
    tbl[9]  = '{p: 657, de: 0, hs: 1, sof: 0, eol: 0, rgb: 24'h000000};
    tbl[10] = '{p: 658, de: 1, hs: 1, sof: 0, eol: 0, rgb: 24'hFFFFFF};

    cfg[0] = '{hres: 640, hfp: 8, hsync: 2, hbp: 8, vres: 480, vfp: 8, vsync: 4, vbp: 8, cw: 8, hpol: 0, vpol: 0};
    cfg[1] = '{hres: 40, hfp: 3, hsync: 2, hbp: 3, vres: 70, vfp: 2, vsync: 2, vbp: 2, cw: 8, hpol: 0, vpol: 0};
    cfg[2] = '{hres: 100, hfp: 4, hsync: 2, hbp: 4, vres: 4, vfp: 1, vsync: 1, vbp: 1, cw: 6, hpol: 1, vpol: 1};
    for (int i = 0; i < 3; i++) begin
      p[i] = -1;
      fm[i] = 2'd0;
      sol[i] = '0;
    end

    // Colour bars and line timing on default geometry, plus frame totals on dut_b
    ce = 1'b1; mode = 2'd0; solid = 24'h0;
    do_reset();
    chk(2, "rst_hs_pol1", hs_c, 0);
    chk(0, "rst_hs_pol0", hs_a, 1);
    for (int k = 0; k < 11; k++) begin
      run_until(0, tbl[k].p, 1000);
      chk(0, "tbl_de", de_a, tbl[k].de);
      chk(0, "tbl_hs", hs_a, tbl[k].hs);
      chk(0, "tbl_sof", sof_a, tbl[k].sof);
      chk(0, "tbl_eol", eol_a, tbl[k].eol);
      chk(0, "tbl_rgb", {r_a, g_a, b_a}, tbl[k].rgb);
    end
    run_until(2, 770 + 83, 1000);
    chk(2, "bar6_blue", {r_c, g_c, b_c}, 18'h0003F);
    run_until(2, 770 + 96, 100);
    for (int k = 0; k < 4; k++) begin
      chk(2, "bar_rem_de", de_c, 1);
      chk(2, "bar_rem_black", {r_c, g_c, b_c}, 0);
      step();
    end
    run_until(1, 7295, 8000);
    chk(1, "frames_done", fc_b, 2);
    chk(1, "de_total", de_cnt_b, 2 * 40 * 70);
    chk(1, "sof_count", sof_cnt_b, 2);
    chk(1, "sof_period", sof_gap_b, 3648);

    // Moving ramp, including channel wrap on the 6-bit instance
    mode = 2'd1;
    do_reset();
    run_until(2, 5, 100);
    chk(0, "ramp_f0_p5", {r_a, g_a, b_a}, 24'h050505);
    chk(2, "ramp_c_p5", r_c, 5);
    run_until(2, 99, 200);
    chk(2, "ramp_c_wrap", r_c, 35);
    step();
    chk(2, "ramp_blank", {r_c, g_c, b_c}, 0);
    run_until(2, 3 * 770 + 70, 3000);
    chk(2, "ramp_f3", {r_c, g_c, b_c}, {6'd9, 6'd9, 6'd9});
    chk(2, "ramp_fc", fc_c, 3);

    // Mid-frame mode switch takes effect only at the next frame
    mode = 2'd0;
    do_reset();
    run_until(1, 21 * 48 + 5, 2000);
    mode = 2'd3; solid = 24'h123456;
    run_until(1, 21 * 48 + 10, 100);
    chk(1, "switch_still_bars", {r_b, g_b, b_b}, 24'h00FFFF);
    run_until(1, 3648, 4000);
    chk(1, "switch_solid", {r_b, g_b, b_b}, 24'h123456);
    chk(1, "switch_sof", sof_b, 1);

    // Alternating ce: every output, pulses included, held for two clocks
    mode = 2'd0;
    do_reset();
    eol_cnt = 0;
    ce = 1'b1; step(); chk(1, "ce_sof_first", sof_b, 1);
    ce = 1'b0; step(); chk(1, "ce_sof_hold", sof_b, 1);
    ce = 1'b1; step(); chk(1, "ce_sof_next", sof_b, 0);
    for (int k = 0; k < 197; k++) begin
      ce = (k % 2 == 1);
      step();
      if (eol_b) eol_cnt++;
    end
    chk(1, "ce_eol_cycles", eol_cnt, 4);

    // Reset in mid-frame
    ce = 1'b1;
    do_reset();
    run_until(1, 20 * 48 + 30, 2000);
    rst = 1'b1;
    step();
    chk(1, "midrst_de", de_b, 0);
    chk(1, "midrst_hs", hs_b, 1);
    chk(1, "midrst_vs", vs_b, 1);
    chk(1, "midrst_fc", fc_b, 0);
    chk(2, "midrst_hs_pol1", hs_c, 0);
    rst = 1'b0;
    step();
    chk(1, "midrst_sof", sof_b, 1);
    chk(1, "midrst_de_first", de_b, 1);

    // Random ce, mode, solid colour and occasional reset
    for (int k = 0; k < 20000; k++) begin
      ce = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) solid = 24'($urandom());
      rst = ($urandom_range(0, 2999) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
